demux_1x4_reg: RTL and testbench
================================

// Module: demux_1x4_reg
// PURPOSE
//  Registered 1-to-4 demultiplexer: opposite direction of the 4:1 MUX. One 4-bit input stream
//  (valid/ready) is routed to one of four output channels, each with its own 1-deep holding slot.
//  Sits downstream of the ALU datapath (AND/OR/XOR/adder results) and fans results to consumers.
// PARAMETERS
//  WIDTH      4   data width of input and every output channel
//  CNT_W      8   width of the accepted-beat counter (xfer_count)
// PORTS
//  clk         in   1         single clock; all state updates on rising edge
//  reset       in   1         synchronous, active-high reset
//  in_data     in   WIDTH     input beat
//  in_valid    in   1         input beat present
//  in_ready    out  1         demux can accept beat for the selected channel
//  in_sel      in   2         target channel 0..3 (sampled with the beat)
//  out_data0..3 out WIDTH     channel k held data
//  out_valid   out  4         bit k: channel k slot full
//  out_ready   in   4         bit k: consumer k takes slot this cycle
//  xfer_count  out  CNT_W     number of accepted input beats, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset (sync, reset=1 at edge): all slots EMPTY, out_valid=4'b0, out_data0..3=0, xfer_count=0,
//    RR pointer=0. Reset asserted mid-transfer discards held data; no beat accepted that cycle.
//  - Per-channel FSM: EMPTY -> FULL on accept to k; FULL -> EMPTY on out_valid[k]&out_ready[k]
//    with no new accept to k; FULL -> FULL (data replaced) on simultaneous drain+accept to k.
//  - in_ready = !out_valid[sel] | out_ready[sel], sel = effective channel; combinational, no loop
//    through in_valid. Accept = in_valid & in_ready.
//  - Latency: accepted beat visible on out_data<sel>/out_valid[sel] one cycle after accept.
//  - Only the selected channel changes on an accept; other channels hold or drain independently.
//  - out_data<k> stable while out_valid[k]=1 and out_ready[k]=0 (no overwrite when full).
//  - xfer_count increments by 1 per accept, modulo 2^CNT_W; never on reset cycle.
//  - in_valid=0: no state change except drains. in_sel changes while not accepted: no effect.
// CONFIGURATION
//  - ROUND_ROBIN_EN defined: in_sel ignored; effective channel = 2-bit RR pointer, pointer
//    increments (3 -> 0 wrap) after every accept; in_ready reflects pointer's channel only.
//  - ROUND_ROBIN_EN undefined: effective channel = in_sel; no pointer register exists.
// STRUCTURE
//  - Package demux_pkg: WIDTH/CNT_W defaults, NUM_CH=4, SEL_W=2, typedef enum {CH_EMPTY, CH_FULL}.
//  - Sub-module demux_ch_slot (one channel: state + data register, load/drain inputs), 4 instances;
//    top holds sel decode, in_ready mux, RR pointer, xfer_count.
// TESTING
//  1. reset=1 two cycles, in_valid=1 -> out_valid=0000, xfer_count=0, all out_data=0.
//  2. in_sel=2, in_data=4'hB, out_ready=0 -> next cycle out_valid=0100, out_data2=B;
//     second beat to ch2 (4'h4) -> in_ready=0, out_data2 stays B.
//  3. ch1 full (4'hA), out_ready[1]=1 and new beat 4'hE to ch1 same cycle -> out_valid[1] stays 1,
//     out_data1=E next cycle, xfer_count +1.
//  4. 256 back-to-back accepts with all out_ready=1 -> xfer_count wraps 255 -> 0.
//  5. ch3 full, assert reset with in_valid=1 -> next cycle out_valid=0000, xfer_count=0.
//  6. ROUND_ROBIN_EN: beats E,A,B,4 with in_sel=0 -> land on ch0,1,2,3; 5th beat back on ch0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg -- shared widths and channel-slot state encoding for demux_1x4_reg. Rev 1.0
`default_nettype none

package demux_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [0:0] {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/demux_ch_slot.sv
// demux_ch_slot -- one output channel: 1-deep holding slot with EMPTY/FULL state. Rev 1.0
`default_nettype none

module demux_ch_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  ch_state_t state;

  // A load wins over a drain, so a simultaneous drain+load stays FULL with new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CH_EMPTY;
      data  <= '0;
    end else if (load) begin
      state <= CH_FULL;
      data  <= load_data;
    end else if (state == CH_FULL && drain) begin
      state <= CH_EMPTY;
    end
  end

  assign valid = (state == CH_FULL);

endmodule

`default_nettype wire

// File: rtl/demux_1x4_reg.sv
// demux_1x4_reg -- registered 1:4 valid/ready demux; define ROUND_ROBIN_EN to route by RR pointer. Rev 1.0
`default_nettype none

module demux_1x4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  xfer_count
);

  logic [SEL_W-1:0]  eff_sel;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  slot_data [NUM_CH];

`ifdef ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_ptr;
  logic             unused_in_sel;

  assign unused_in_sel = ^in_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

  assign eff_sel = rr_ptr;
`else
  assign eff_sel = in_sel;
`endif

  // Ready depends only on slot state and consumer ready, never on in_valid.
  assign in_ready = !out_valid[eff_sel] | out_ready[eff_sel];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign load[k] = accept && (eff_sel == SEL_W'(k));

      demux_ch_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load[k]),
        .load_data (in_data),
        .drain     (out_ready[k]),
        .valid     (out_valid[k]),
        .data      (slot_data[k])
      );
    end
  endgenerate

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule

`default_nettype wire

// File: tb/tb_demux_1x4_reg.sv
// tb_demux_1x4_reg -- scoreboard bench for demux_1x4_reg (ROUND_ROBIN_EN aware). Rev 1.0
`default_nettype none

module tb_demux_1x4_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] xfer_count;
  logic [3:0] od [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] data;
  } sb_t;

  sb_t sb_q[$];

  // Reference model state
  logic [3:0] m_full;
  logic [3:0] m_data [4];
  logic [7:0] m_cnt;
  logic [1:0] m_rr;
  logic       exp_ready;
  logic       obs_ready;

  always #5 clk = ~clk;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  demux_1x4_reg dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  // Drive one cycle, update the model, push accepted beats to the scoreboard.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] r, input logic rs);
    logic [1:0] eff;
    logic       acc;
    reset     = rs;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    obs_ready = in_ready;
`ifdef ROUND_ROBIN_EN
    eff = m_rr;
`else
    eff = s;
`endif
    exp_ready = !m_full[eff] | r[eff];
    acc = v & exp_ready & !rs;
    if (rs) begin
      m_full = 4'b0;
      m_cnt  = 8'd0;
      m_rr   = 2'd0;
      for (int k = 0; k < 4; k++) m_data[k] = 4'h0;
    end else begin
      m_full = m_full & ~r;
      if (acc) begin
        m_full[eff] = 1'b1;
        m_data[eff] = d;
        m_cnt       = m_cnt + 8'd1;
        m_rr        = m_rr + 2'd1;
        sb_q.push_back('{ch: eff, data: d});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sb_take(output sb_t e, output bit ok);
    ok = (sb_q.size() != 0);
    if (ok) e = sb_q.pop_front();
    else    e = '{ch: 2'd0, data: 4'h0};
  endtask

  task automatic test_reset;
    cycle(1'b1, 2'd0, 4'h5, 4'h0, 1'b1);
    cycle(1'b1, 2'd1, 4'h6, 4'h0, 1'b1);
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (xfer_count !== 8'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", xfer_count);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (od[k] !== 4'h0) begin
        failures++; $display("FAIL reset_data%0d got=%h exp=0", k, od[k]);
      end
    end
  endtask

  task automatic test_hold_when_full;
    sb_t e; bit ok;
    cycle(1'b1, 2'd2, 4'hB, 4'h0, 1'b0);
    sb_take(e, ok);
    checks++;
    if (!ok || od[e.ch] !== e.data || out_valid[e.ch] !== 1'b1) begin
      failures++; $display("FAIL hold_first got=%h exp=%h sb_ok=%0d", od[e.ch], e.data, ok);
    end
    checks++;
    if (out_valid !== 4'b0100) begin
      failures++; $display("FAIL hold_valid got=%b exp=0100", out_valid);
    end
    cycle(1'b1, 2'd2, 4'h4, 4'h0, 1'b0);
    checks++;
    if (obs_ready !== exp_ready || exp_ready !== 1'b0) begin
      failures++; $display("FAIL hold_ready got=%b exp=%b", obs_ready, exp_ready);
    end
    checks++;
    if (out_data2 !== 4'hB) begin
      failures++; $display("FAIL hold_data2 got=%h exp=b", out_data2);
    end
    checks++;
    if (xfer_count !== m_cnt) begin
      failures++; $display("FAIL hold_count got=%0d exp=%0d", xfer_count, m_cnt);
    end
  endtask

  task automatic test_drain_and_replace;
    sb_t e; bit ok;
    cycle(1'b1, 2'd1, 4'hA, 4'h0, 1'b0);
    sb_take(e, ok);
    checks++;
    if (!ok || od[e.ch] !== e.data) begin
      failures++; $display("FAIL repl_first got=%h exp=%h sb_ok=%0d", od[e.ch], e.data, ok);
    end
    cycle(1'b1, 2'd1, 4'hE, 4'b0010, 1'b0);
    checks++;
    if (obs_ready !== 1'b1) begin
      failures++; $display("FAIL repl_ready got=%b exp=1", obs_ready);
    end
    sb_take(e, ok);
    checks++;
    if (!ok || out_data1 !== 4'hE || out_valid[1] !== 1'b1) begin
      failures++; $display("FAIL repl_data1 got=%h/%b exp=e/1", out_data1, out_valid[1]);
    end
    checks++;
    if (out_valid !== m_full || xfer_count !== m_cnt) begin
      failures++; $display("FAIL repl_state got=%b/%0d exp=%b/%0d", out_valid, xfer_count, m_full, m_cnt);
    end
  endtask

  task automatic test_idle_sel_change;
    sb_t e; bit ok;
    cycle(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
    cycle(1'b1, 2'd0, 4'hC, 4'h0, 1'b0);
    sb_take(e, ok);
    checks++;
    if (!ok || od[e.ch] !== e.data || out_valid[e.ch] !== 1'b1) begin
      failures++; $display("FAIL idle_load got=%h exp=%h sb_ok=%0d", od[e.ch], e.data, ok);
    end
    cycle(1'b0, 2'd2, 4'h5, 4'h0, 1'b0);
    cycle(1'b0, 2'd3, 4'h6, 4'h0, 1'b0);
    checks++;
    if (out_valid !== m_full || od[e.ch] !== m_data[e.ch] || xfer_count !== m_cnt) begin
      failures++; $display("FAIL idle_hold got=%b/%h/%0d exp=%b/%h/%0d",
                           out_valid, od[e.ch], xfer_count, m_full, m_data[e.ch], m_cnt);
    end
  endtask

  task automatic test_back_to_back_wrap;
    sb_t e; bit ok;
    logic [7:0] c0;
    int bad = 0;
    bit saw_zero = 0;
    cycle(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
    c0 = m_cnt;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 2'(i % 4), 4'($urandom_range(0, 15)), 4'hF, 1'b0);
      sb_take(e, ok);
      checks++;
      if (!ok || od[e.ch] !== e.data || xfer_count !== m_cnt) begin
        failures++;
        if (bad < 5) $display("FAIL b2b_beat%0d got=%h/%0d exp=%h/%0d", i, od[e.ch], xfer_count, e.data, m_cnt);
        bad++;
      end
      if (m_cnt == 8'd0 && xfer_count === 8'd0) saw_zero = 1;
    end
    checks++;
    if (xfer_count !== c0 || !saw_zero) begin
      failures++; $display("FAIL b2b_wrap got=%0d exp=%0d wrapped=%0d", xfer_count, c0, saw_zero);
    end
  endtask

  task automatic test_reset_mid_transfer;
    sb_t e; bit ok;
    cycle(1'b1, 2'd3, 4'h7, 4'b1000, 1'b0);
    sb_take(e, ok);
    checks++;
    if (!ok || out_data3 !== 4'h7 || out_valid[3] !== 1'b1) begin
      failures++; $display("FAIL rmid_load got=%h/%b exp=7/1", out_data3, out_valid[3]);
    end
    cycle(1'b1, 2'd0, 4'h9, 4'h0, 1'b1);
    checks++;
    if (out_valid !== 4'b0000 || xfer_count !== 8'd0 || out_data3 !== 4'h0 || out_data0 !== 4'h0) begin
      failures++; $display("FAIL rmid_state got=%b/%0d/%h/%h exp=0000/0/0/0",
                           out_valid, xfer_count, out_data3, out_data0);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL rmid_sb got=%0d exp=0", sb_q.size());
    end
  endtask

`ifdef ROUND_ROBIN_EN
  task automatic test_round_robin;
    sb_t e; bit ok;
    logic [3:0] beats [5];
    beats = '{4'hE, 4'hA, 4'hB, 4'h4, 4'h5};
    cycle(1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'd0, beats[i], 4'hF, 1'b0);
      sb_take(e, ok);
      checks++;
      if (!ok || od[i % 4] !== beats[i] || out_valid[i % 4] !== 1'b1) begin
        failures++; $display("FAIL rr_beat%0d ch%0d got=%h/%b exp=%h/1", i, i % 4, od[i % 4], out_valid[i % 4], beats[i]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'h0;
    m_full = 4'b0; m_cnt = 8'd0; m_rr = 2'd0;
    for (int k = 0; k < 4; k++) m_data[k] = 4'h0;
    @(posedge clk); #1;
    test_reset;
    test_hold_when_full;
    test_drain_and_replace;
    test_idle_sel_change;
    test_back_to_back_wrap;
    test_reset_mid_transfer;
`ifdef ROUND_ROBIN_EN
    test_round_robin;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
